// File: rtl/rr_dispatcher.sv
// Round-robin dispatcher: one valid/ready input stream fanned out to OUT_NUM
// registered output channels, rotating fairly among channels with free space.
module rr_dispatcher #(
    parameter int OUT_NUM = 8,
    parameter int DATA_W  = 32,
    parameter int IDX_W   = (OUT_NUM > 1) ? $clog2(OUT_NUM) : 1
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      in_valid,
    input  logic [DATA_W-1:0]         in_data,
    output logic                      in_ready,
    output logic [OUT_NUM-1:0]        out_valid,
    output logic [OUT_NUM*DATA_W-1:0] out_data,
    input  logic [OUT_NUM-1:0]        out_ready,
    output logic [IDX_W-1:0]          sel_idx
);

    logic [OUT_NUM-1:0] mask;
    logic [OUT_NUM-1:0] empty;
    logic [OUT_NUM-1:0] masked_empty;
    logic [IDX_W-1:0]   sel;
    logic [IDX_W-1:0]   sel_m;
    logic [IDX_W-1:0]   sel_u;
    logic               hit_m;
    logic               hit_u;
    logic               accept;

    // Eligibility comes from registered occupancy only, so out_ready never
    // reaches in_ready or the channel choice combinationally.
    assign empty        = ~out_valid;
    assign masked_empty = empty & mask;
    assign in_ready     = |empty;
    assign accept       = in_valid & in_ready;

    // Pick the lowest empty channel above the last one served, else wrap to the lowest empty channel.
    always_comb begin
        sel_m = '0;
        sel_u = '0;
        hit_m = 1'b0;
        hit_u = 1'b0;
        for (int unsigned i = 0; i < OUT_NUM; i++) begin
            if (masked_empty[i] && !hit_m) begin
                hit_m = 1'b1;
                sel_m = IDX_W'(i);
            end
            if (empty[i] && !hit_u) begin
                hit_u = 1'b1;
                sel_u = IDX_W'(i);
            end
        end
        sel = hit_m ? sel_m : sel_u;
    end

    // Per-channel holding registers: drain on handshake, load on accept.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            out_valid <= '0;
            out_data  <= '0;
        end else begin
            for (int unsigned i = 0; i < OUT_NUM; i++) begin
                if (out_valid[i] && out_ready[i]) begin
                    out_valid[i] <= 1'b0;
                end
                if (accept && (sel == IDX_W'(i))) begin
                    out_valid[i]                   <= 1'b1;
                    out_data[i*DATA_W +: DATA_W]   <= in_data;
                end
            end
        end
    end

    // Rotation state: remember the served channel and mask it and everything below.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            mask    <= '1;
            sel_idx <= '0;
        end else if (accept) begin
            sel_idx <= sel;
            for (int unsigned i = 0; i < OUT_NUM; i++) begin
                mask[i] <= (IDX_W'(i) > sel);
            end
        end
    end

endmodule
